// File: rtl/clock_gen_pkg.sv
// rtl/clock_gen_pkg.sv - shared types and constants for the retunable clock-enable generator
package clock_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_DIVIDE = 3'd2,
        ST_ROUND  = 3'd3,
        ST_ARM    = 3'd4
    } state_t;

    // Highest frequency the accumulator can represent without aliasing
    function automatic int unsigned max_freq(input int unsigned clock_freq);
        return clock_freq / 2;
    endfunction

    // One quotient bit per cycle, one cycle per accumulator bit
    function automatic int div_iterations(input int counter_width);
        return counter_width;
    endfunction

    localparam int DEFAULT_DIV_ITER = div_iterations(32);

endpackage

// File: rtl/clock_gen_divider.sv
// rtl/clock_gen_divider.sv - sequential restoring unsigned divider, one quotient bit per cycle
// The upper DIVISOR_W bits of the dividend must be below the divisor, so the
// quotient fits in DIVIDEND_W-DIVISOR_W bits and takes that many cycles.
// o_quotient/o_remainder carry the final result during the cycle o_done is high.
module clock_gen_divider #(
    parameter int DIVIDEND_W = 64,
    parameter int DIVISOR_W  = 32
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_start,
    input  logic [DIVIDEND_W-1:0]            i_dividend,
    input  logic [DIVISOR_W-1:0]             i_divisor,
    output logic                             o_done,
    output logic [DIVIDEND_W-DIVISOR_W-1:0]  o_quotient,
    output logic [DIVISOR_W-1:0]             o_remainder
);

    localparam int QUO_W = DIVIDEND_W - DIVISOR_W;
    localparam int CNT_W = $clog2(QUO_W + 1);

    logic [DIVISOR_W-1:0] r_rem;
    logic [QUO_W-1:0]     r_quo;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_busy;

    logic [DIVISOR_W:0]   w_shift;
    logic [DIVISOR_W-1:0] w_sub;
    logic                 w_ge;
    logic [DIVISOR_W-1:0] w_rem_next;
    logic [QUO_W-1:0]     w_quo_next;

    // The true difference is always below the divisor, so the low bits suffice
    assign w_shift    = {r_rem, r_quo[QUO_W-1]};
    assign w_ge       = (w_shift >= {1'b0, i_divisor});
    assign w_sub      = w_shift[DIVISOR_W-1:0] - i_divisor;
    assign w_rem_next = w_ge ? w_sub : w_shift[DIVISOR_W-1:0];
    assign w_quo_next = {r_quo[QUO_W-2:0], w_ge};

    assign o_done      = r_busy && (r_cnt == CNT_W'(1));
    assign o_quotient  = w_quo_next;
    assign o_remainder = w_rem_next;

    // Shift-subtract iteration; low dividend bits shift out as quotient bits shift in
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_rem  <= i_dividend[DIVIDEND_W-1:QUO_W];
            r_quo  <= i_dividend[QUO_W-1:0];
            r_cnt  <= CNT_W'(QUO_W);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clock_gen_tuner.sv
// rtl/clock_gen_tuner.sv - retunable phase-accumulator clock enable; CLOCK_GEN_TUNER_ROUND_EN selects round-to-nearest increment
module clock_gen_tuner
    import clock_gen_pkg::*;
#(
    parameter int          COUNTER_WIDTH = 32,
    parameter int unsigned CLOCK_FREQ    = 25000000,
    parameter int          FREQ_WIDTH    = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic [FREQ_WIDTH-1:0]    i_req_freq,
    output logic                     o_busy,
    output logic                     o_err,
    output logic                     o_locked,
    output logic [COUNTER_WIDTH-1:0] o_inc,
    output logic                     o_active
);

    localparam int W        = COUNTER_WIDTH;
    localparam int DIV_ITER = div_iterations(W);
    localparam logic [FREQ_WIDTH-1:0] MAX_F   = FREQ_WIDTH'(max_freq(CLOCK_FREQ));
    localparam logic [FREQ_WIDTH-1:0] DIVISOR = FREQ_WIDTH'(CLOCK_FREQ);

    state_t                r_state;
    state_t                w_next_state;
    logic [FREQ_WIDTH-1:0] r_freq;
    logic [W-1:0]          r_acc;
    logic [W-1:0]          r_inc;
    logic [W-1:0]          r_pending;
    logic                  r_active;
    logic                  r_locked;

    logic [W:0]            w_sum;
    logic                  w_xfer;
    logic                  w_too_big;
    logic                  w_zero;
    logic                  w_div_start;
    logic                  w_div_done;
    logic                  w_arm_load;
    logic [W-1:0]          w_div_quo;
    logic [FREQ_WIDTH-1:0] w_div_rem;

    assign w_sum     = {1'b0, r_acc} + {1'b0, r_inc};
    assign w_xfer    = i_req_valid && o_req_ready;
    assign w_too_big = (r_freq > MAX_F);
    assign w_zero    = (r_freq == '0);

    assign o_inc    = r_inc;
    assign o_active = r_active;
    assign o_locked = r_locked;

    // Captured frequency is below CLOCK_FREQ, so the quotient fits in DIV_ITER bits
    clock_gen_divider #(
        .DIVIDEND_W (DIV_ITER + FREQ_WIDTH),
        .DIVISOR_W  (FREQ_WIDTH)
    ) u_divider (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (w_div_start),
        .i_dividend  ({r_freq, {DIV_ITER{1'b0}}}),
        .i_divisor   (DIVISOR),
        .o_done      (w_div_done),
        .o_quotient  (w_div_quo),
        .o_remainder (w_div_rem)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (i_req_valid) w_next_state = ST_CHECK;
            ST_CHECK: begin
                if (w_too_big)   w_next_state = ST_IDLE;
                else if (w_zero) w_next_state = ST_ARM;
                else             w_next_state = ST_DIVIDE;
            end
`ifdef CLOCK_GEN_TUNER_ROUND_EN
            ST_DIVIDE: if (w_div_done) w_next_state = ST_ROUND;
            ST_ROUND:  w_next_state = ST_ARM;
`else
            ST_DIVIDE: if (w_div_done) w_next_state = ST_ARM;
`endif
            ST_ARM:    if (w_arm_load) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Outputs and control strobes decoded from the current state
    always_comb begin
        o_req_ready = (r_state == ST_IDLE);
        o_busy      = (r_state != ST_IDLE);
        o_err       = (r_state == ST_CHECK) && w_too_big;
        w_div_start = (r_state == ST_CHECK) && !w_too_big && !w_zero;
        w_arm_load  = (r_state == ST_ARM) && ((r_inc == '0) || w_sum[W]);
    end

    // Request frequency is latched only on a handshake
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_freq <= '0;
        end else if (w_xfer) begin
            r_freq <= i_req_freq;
        end
    end

    // Free-running accumulator; retuning never disturbs its phase
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc    <= '0;
            r_active <= 1'b0;
        end else begin
            r_acc    <= w_sum[W-1:0];
            r_active <= w_sum[W];
        end
    end

    // New increment takes effect on a carry edge so the interval in flight completes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inc    <= '0;
            r_locked <= 1'b0;
        end else if (w_arm_load) begin
            r_inc    <= r_pending;
            r_locked <= (r_pending != '0);
        end
    end

`ifdef CLOCK_GEN_TUNER_ROUND_EN
    logic [FREQ_WIDTH-1:0] r_rem;
    logic                  w_round_up;

    assign w_round_up = ({r_rem, 1'b0} >= {1'b0, DIVISOR});

    // Keep the remainder for the rounding decision in the following cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rem <= '0;
        end else if ((r_state == ST_DIVIDE) && w_div_done) begin
            r_rem <= w_div_rem;
        end
    end

    // Pending increment: zero request, divider quotient, then rounding with saturation
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending <= '0;
        end else if ((r_state == ST_CHECK) && w_zero) begin
            r_pending <= '0;
        end else if ((r_state == ST_DIVIDE) && w_div_done) begin
            r_pending <= w_div_quo;
        end else if ((r_state == ST_ROUND) && w_round_up && !(&r_pending)) begin
            r_pending <= r_pending + W'(1);
        end
    end
`else
    logic w_unused_rem;

    assign w_unused_rem = ^w_div_rem;

    // Pending increment: zero request or truncated divider quotient
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending <= '0;
        end else if ((r_state == ST_CHECK) && w_zero) begin
            r_pending <= '0;
        end else if ((r_state == ST_DIVIDE) && w_div_done) begin
            r_pending <= w_div_quo;
        end
    end
`endif

endmodule

// File: tb/tb_clock_gen_tuner.sv
// tb/tb_clock_gen_tuner.sv - randomized self-checking bench for clock_gen_tuner with a cycle-level reference model
module tb_clock_gen_tuner;

    localparam int          W  = 32;
    localparam int unsigned CF = 25000000;
    localparam int          FW = 32;
`ifdef CLOCK_GEN_TUNER_ROUND_EN
    localparam int DIV_CYCLES = W + 1;
    localparam bit RND        = 1'b1;
`else
    localparam int DIV_CYCLES = W;
    localparam bit RND        = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [FW-1:0] req_freq = '0;
    logic          req_ready, busy, err, locked, active;
    logic [W-1:0]  inc;

    always #5 clk = ~clk;

    clock_gen_tuner #(
        .COUNTER_WIDTH (W),
        .CLOCK_FREQ    (CF),
        .FREQ_WIDTH    (FW)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_freq  (req_freq),
        .o_busy      (busy),
        .o_err       (err),
        .o_locked    (locked),
        .o_inc       (inc),
        .o_active    (active)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: 0 idle, 1 checking, 2 computing, 3 waiting to apply
    int          m_phase;
    int          m_wait;
    logic [31:0] m_acc, m_inc, m_pending, m_freq;
    logic        m_locked, m_active;

    int cyc = 0;
    int last_act = -1;
    int gaps[$];

    function automatic logic [31:0] ref_inc(input logic [31:0] f);
        longint unsigned num, q, r;
        num = longint'(f) << W;
        q   = num / CF;
        r   = num % CF;
        if (RND && (2 * r >= CF) && (q < 64'hFFFF_FFFF)) q = q + 1;
        return q[31:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_wait = 0;
        m_acc = '0; m_inc = '0; m_pending = '0; m_freq = '0;
        m_locked = 1'b0; m_active = 1'b0;
    endtask

    task automatic model_tick();
        logic [32:0] sum;
        sum = {1'b0, m_acc} + {1'b0, m_inc};
        case (m_phase)
            0: if (req_valid) begin m_freq = req_freq; m_phase = 1; end
            1: begin
                if (m_freq > CF / 2) m_phase = 0;
                else if (m_freq == 0) begin m_pending = '0; m_phase = 3; end
                else begin m_pending = ref_inc(m_freq); m_wait = DIV_CYCLES - 1; m_phase = 2; end
            end
            2: if (m_wait == 0) m_phase = 3; else m_wait--;
            default: if (m_inc == 0 || sum[32]) begin
                m_inc = m_pending; m_locked = (m_pending != 0); m_phase = 0;
            end
        endcase
        m_acc    = sum[31:0];
        m_active = sum[32];
    endtask

    task automatic compare();
        cyc++;
        check("ready",  req_ready, m_phase == 0);
        check("busy",   busy,      m_phase != 0);
        check("err",    err,       (m_phase == 1) && (m_freq > CF / 2));
        check("locked", locked,    m_locked);
        check("inc",    inc,       m_inc);
        check("active", active,    m_active);
        if (active === 1'b1) begin
            if (last_act >= 0) gaps.push_back(cyc - last_act);
            last_act = cyc;
        end
    endtask

    task automatic step(input logic v, input logic [31:0] f);
        req_valid = v;
        req_freq  = f;
        if (rst_n) model_tick();
        @(negedge clk);
        compare();
    endtask

    task automatic wait_idle(input int bound, input string name);
        int n = 0;
        while (m_phase != 0 && n < bound) begin
            step(1'b0, '0);
            n++;
        end
        check({name, "_timeout"}, n < bound, 1);
        check({name, "_ready"}, req_ready, 1);
    endtask

    function automatic logic [31:0] pick_freq();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd12500000;
            2:       return 32'd12500001 + $urandom_range(0, 100000000);
            default: return $urandom_range(1000000, 12500000);
        endcase
    endfunction

    initial begin
        int lat, cnt, xfers;
        logic [31:0] f;

        model_reset();
        @(negedge clk);
        compare();
        check("rst_inc", inc, 0);
        check("rst_ready", req_ready, 1);
        check("rst_locked", locked, 0);
        rst_n = 1'b1;
        repeat (3) step(1'b0, '0);

        // 12.5 MHz from reset: applied immediately on the first ARM cycle
        check("model_12m5", ref_inc(32'd12500000), 32'h8000_0000);
        step(1'b1, 32'd12500000);
        check("err_12m5", err, 0);
        lat = 0;
        while (inc == 0 && lat < 100) begin step(1'b0, '0); lat++; end
        check("latency_12m5", lat, DIV_CYCLES + 2);
        check("inc_12m5", inc, 32'h8000_0000);
        check("locked_12m5", locked, 1);
        gaps.delete(); last_act = -1;
        repeat (9) step(1'b0, '0);
        check("gapcount_12m5", gaps.size() >= 3, 1);
        foreach (gaps[i]) check("gap_12m5", gaps[i], 2);

        // Retune to 6.25 MHz: switch on a carry, intervals only 2 or 4
        gaps.delete(); last_act = -1;
        step(1'b1, 32'd6250000);
        wait_idle(200, "req_6m25");
        repeat (12) step(1'b0, '0);
        check("inc_6m25", inc, 32'h4000_0000);
        foreach (gaps[i]) check("gap_switch", (gaps[i] == 2) || (gaps[i] == 4), 1);

        // Out-of-range request is rejected with a single err pulse
        step(1'b1, 32'd12500001);
        check("err_pulse", err, 1);
        step(1'b0, '0);
        check("err_cleared", err, 0);
        check("ready_after_err", req_ready, 1);
        check("inc_after_err", inc, 32'h4000_0000);

        // Zero request stops the enable after the final carry
        step(1'b1, 32'd0);
        wait_idle(200, "req_zero");
        check("inc_zero", inc, 0);
        check("locked_zero", locked, 0);
        cnt = 0;
        repeat (20) begin step(1'b0, '0); if (active) cnt++; end
        check("no_pulse_after_zero", cnt, 0);

        // 1 Hz: the smallest non-zero increment
        step(1'b1, 32'd1);
        wait_idle(200, "req_1hz");
        check("inc_1hz", inc, RND ? 32'd172 : 32'd171);
        check("locked_1hz", locked, 1);

        // Reset in the middle of a divide
        step(1'b1, 32'd3000000);
        repeat (10) step(1'b0, '0);
        rst_n = 1'b0;
        model_reset();
        step(1'b0, '0);
        check("midrst_inc", inc, 0);
        check("midrst_busy", busy, 0);
        check("midrst_locked", locked, 0);
        rst_n = 1'b1;

        // Held valid is taken again only once the block returns to idle
        xfers = 0;
        for (int i = 0; i < 40; i++) begin
            if (req_ready) xfers++;
            step(1'b1, 32'd3000000);
        end
        wait_idle(200, "held");
        check("held_xfers", xfers, 2);
        check("inc_3m", inc, RND ? 32'd515396076 : 32'd515396075);

        // Randomized requests, with stray valids while busy
        for (int r = 0; r < 25; r++) begin
            repeat ($urandom_range(0, 3)) step(1'b0, $urandom);
            step(1'b1, pick_freq());
            cnt = 0;
            while (m_phase != 0 && cnt < 300) begin
                f = pick_freq();
                step($urandom_range(0, 3) == 0, f);
                cnt++;
            end
            wait_idle(300, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
